// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer.
//   state_t     : sequencer state (RUN, MEM_WAIT)
//   DEF_REG_W   : default register-index width
//   DEF_TIMEOUT : default number of tolerated consecutive memory-wait cycles
//   DEF_CNT_W   : default width of the wait counter and performance counters
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int DEF_REG_W   = 4;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_CNT_W   = 16;

endpackage : pipe_ctrl_pkg

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational RAW-hazard detector for the ID stage.
// Ports:
//   id_src1, id_src2      : ID-stage source register indices
//   id_uses_src1          : ID instruction reads id_src1
//   id_two_src            : ID instruction reads id_src2
//   exe_dest, exe_wb_en   : producer in EXE
//   exe_mem_r_en          : EXE producer is a load
//   mem_dest, mem_wb_en   : producer in MEM
//   forward_en            : forwarding unit active
//   hazard                : a bubble must be inserted
// -----------------------------------------------------------------------------
module hazard_detect #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_uses_src1,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             forward_en,
    output logic             hazard
);

    // Producer slot 0 is EXE, slot 1 is MEM.
    logic [REG_W-1:0] w_dest [2];
    logic             w_wb   [2];
    logic             w_hit  [2];

    assign w_dest[0] = exe_dest;
    assign w_dest[1] = mem_dest;
    assign w_wb[0]   = exe_wb_en;
    assign w_wb[1]   = mem_wb_en;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_producer
            assign w_hit[gi] = w_wb[gi] &
                               ((id_uses_src1 & (id_src1 == w_dest[gi])) |
                                (id_two_src   & (id_src2 == w_dest[gi])));
        end
    endgenerate

    // With forwarding, only a load in EXE cannot be bypassed in time.
    assign hazard = forward_en ? (w_hit[0] & exe_mem_r_en)
                               : (w_hit[0] | w_hit[1]);

endmodule : hazard_detect

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
// Arbitrates memory-wait stalls > taken-branch flushes > RAW bubbles, owns the
// SRAM request and a wait-timeout watchdog.
// Optional feature macro: PIPE_PERF_CNT_EN (adds saturating performance
// counters perf_stall_cycles, perf_bubbles, perf_flushes).
// Ports:
//   clk, rst (async, active-high)
//   id_src1/id_src2/id_two_src/id_uses_src1 : ID-stage operand usage
//   exe_dest/exe_wb_en/exe_mem_r_en         : EXE producer
//   mem_dest/mem_wb_en                      : MEM producer
//   forward_en, branch_taken                : forwarding / branch resolution
//   mem_access, mem_ready                   : MEM-stage access and SRAM done
//   mem_req                                 : request to SRAM controller
//   pc_freeze .. mem_wb_freeze, flushes     : stage register controls
//   mem_timeout_err                         : sticky watchdog error
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = DEF_REG_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_uses_src1,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             forward_en,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             id_exe_freeze,
    output logic             exe_mem_freeze,
    output logic             mem_wb_freeze,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_bubbles,
    output logic [CNT_W-1:0] perf_flushes,
`endif
    output logic             mem_timeout_err
);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_err;

    logic w_hazard;
    logic w_stall_raw;
    logic w_timeout;
    logic w_stall;
    logic w_branch;
    logic w_bubble;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src1 (id_uses_src1),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .forward_en   (forward_en),
        .hazard       (w_hazard)
    );

    assign w_stall_raw = mem_access & ~mem_ready;

    // The watchdog cycle abandons the access: it is treated as non-stalled so
    // the freezes drop and any pending branch/hazard is serviced normally.
    assign w_timeout = (r_state == MEM_WAIT) & w_stall_raw &
                       (r_wait_cnt == CNT_W'(TIMEOUT));
    assign w_stall   = w_stall_raw & ~w_timeout;

    // branch_taken is held stable by the frozen ID/EXE register during a stall,
    // so the single flush pulse falls out naturally in the first free cycle.
    assign w_branch  = ~w_stall & branch_taken;
    assign w_bubble  = ~w_stall & ~branch_taken & w_hazard;

    // Outputs are combinational so a stall freezes the pipe in the same cycle
    // the SRAM reports not-ready; reset forces them all low immediately.
    always_comb begin
        mem_req         = 1'b0;
        pc_freeze       = 1'b0;
        if_id_freeze    = 1'b0;
        if_id_flush     = 1'b0;
        id_exe_flush    = 1'b0;
        id_exe_freeze   = 1'b0;
        exe_mem_freeze  = 1'b0;
        mem_wb_freeze   = 1'b0;
        mem_timeout_err = 1'b0;
        if (!rst) begin
            mem_req         = mem_access;
            pc_freeze       = w_stall | w_bubble;
            if_id_freeze    = w_stall | w_bubble;
            if_id_flush     = w_branch;
            id_exe_flush    = w_branch | w_bubble;
            id_exe_freeze   = w_stall;
            exe_mem_freeze  = w_stall;
            mem_wb_freeze   = w_stall;
            mem_timeout_err = r_timeout_err | w_timeout;
        end
    end

    // Sequencer FSM with wait counter and sticky watchdog flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                r_state       <= RUN;
                r_wait_cnt    <= '0;
            end else if (w_stall) begin
                r_state <= MEM_WAIT;
                if (r_state == RUN) begin
                    r_wait_cnt <= CNT_W'(1);
                end else begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
            end else begin
                // Ready, or the access was withdrawn: back to normal flow.
                r_state    <= RUN;
                r_wait_cnt <= '0;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Counter 0: stall cycles, 1: bubbles, 2: branch flush pulses.
    logic             w_perf_evt [3];
    logic [CNT_W-1:0] r_perf     [3];

    assign w_perf_evt[0] = w_stall;
    assign w_perf_evt[1] = w_bubble;
    assign w_perf_evt[2] = w_branch;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_perf[gi] <= '0;
                end else if (w_perf_evt[gi] && (r_perf[gi] != {CNT_W{1'b1}})) begin
                    r_perf[gi] <= r_perf[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign perf_stall_cycles = r_perf[0];
    assign perf_bubbles      = r_perf[1];
    assign perf_flushes      = r_perf[2];
`endif

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Scoreboard bench: the stimulus process pushes the reference model's expected
// outputs for each cycle; a monitor pops and compares at the falling edge.
// Works with or without PIPE_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int REG_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [REG_W-1:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic             id_two_src = 1'b0, id_uses_src1 = 1'b0;
    logic             exe_wb_en = 1'b0, exe_mem_r_en = 1'b0, mem_wb_en = 1'b0;
    logic             forward_en = 1'b0, branch_taken = 1'b0;
    logic             mem_access = 1'b0, mem_ready = 1'b0;

    logic mem_req, pc_freeze, if_id_freeze, if_id_flush, id_exe_flush;
    logic id_exe_freeze, exe_mem_freeze, mem_wb_freeze, mem_timeout_err;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cycles, perf_bubbles, perf_flushes;
`endif

    pipeline_hazard_ctrl #(
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_two_src      (id_two_src),
        .id_uses_src1    (id_uses_src1),
        .exe_dest        (exe_dest),
        .exe_wb_en       (exe_wb_en),
        .exe_mem_r_en    (exe_mem_r_en),
        .mem_dest        (mem_dest),
        .mem_wb_en       (mem_wb_en),
        .forward_en      (forward_en),
        .branch_taken    (branch_taken),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .mem_req         (mem_req),
        .pc_freeze       (pc_freeze),
        .if_id_freeze    (if_id_freeze),
        .if_id_flush     (if_id_flush),
        .id_exe_flush    (id_exe_flush),
        .id_exe_freeze   (id_exe_freeze),
        .exe_mem_freeze  (exe_mem_freeze),
        .mem_wb_freeze   (mem_wb_freeze),
`ifdef PIPE_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubbles      (perf_bubbles),
        .perf_flushes      (perf_flushes),
`endif
        .mem_timeout_err (mem_timeout_err)
    );

    typedef struct packed {
        logic             rst;
        logic [REG_W-1:0] id_src1;
        logic [REG_W-1:0] id_src2;
        logic             id_two_src;
        logic             id_uses_src1;
        logic [REG_W-1:0] exe_dest;
        logic             exe_wb_en;
        logic             exe_mem_r_en;
        logic [REG_W-1:0] mem_dest;
        logic             mem_wb_en;
        logic             forward_en;
        logic             branch_taken;
        logic             mem_access;
        logic             mem_ready;
    } stim_t;

    // Output order: req pcF ifidF ifidFl idexFl idexF exmemF memwbF err
    typedef struct packed {
        logic [8:0]       outs;
        logic [CNT_W-1:0] stall_cnt;
        logic [CNT_W-1:0] bub_cnt;
        logic [CNT_W-1:0] fl_cnt;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: length of the current run of frozen stall cycles,
    // sticky error and event tallies since reset.
    int          m_run = 0;
    bit          m_err = 1'b0;
    int unsigned m_stall = 0, m_bub = 0, m_fl = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit reads_reg(input stim_t s, input logic [REG_W-1:0] r);
        return (s.id_uses_src1 && (s.id_src1 == r)) || (s.id_two_src && (s.id_src2 == r));
    endfunction

    function automatic logic [CNT_W-1:0] sat(input int unsigned v);
        int unsigned lim;
        lim = (1 << CNT_W) - 1;
        return (v > lim) ? CNT_W'(lim) : CNT_W'(v);
    endfunction

    task automatic apply(input stim_t s, input string tag);
        exp_t e;
        bit   raw, to, stl, dep_exe, dep_mem, haz;
        bit   req, pcf, ifdf, ifdfl, idxfl, stf;
        @(posedge clk);
        #1;
        rst          = s.rst;
        id_src1      = s.id_src1;
        id_src2      = s.id_src2;
        id_two_src   = s.id_two_src;
        id_uses_src1 = s.id_uses_src1;
        exe_dest     = s.exe_dest;
        exe_wb_en    = s.exe_wb_en;
        exe_mem_r_en = s.exe_mem_r_en;
        mem_dest     = s.mem_dest;
        mem_wb_en    = s.mem_wb_en;
        forward_en   = s.forward_en;
        branch_taken = s.branch_taken;
        mem_access   = s.mem_access;
        mem_ready    = s.mem_ready;

        e = '0;
        if (s.rst) begin
            m_run = 0; m_err = 1'b0; m_stall = 0; m_bub = 0; m_fl = 0;
        end else begin
            // Counters show events of earlier cycles only.
            e.stall_cnt = sat(m_stall);
            e.bub_cnt   = sat(m_bub);
            e.fl_cnt    = sat(m_fl);
            raw = s.mem_access && !s.mem_ready;
            to  = raw && (m_run == TIMEOUT);
            stl = raw && !to;
            dep_exe = s.exe_wb_en && reads_reg(s, s.exe_dest);
            dep_mem = s.mem_wb_en && reads_reg(s, s.mem_dest);
            haz = s.forward_en ? (dep_exe && s.exe_mem_r_en) : (dep_exe || dep_mem);
            req = s.mem_access;
            pcf = 0; ifdf = 0; ifdfl = 0; idxfl = 0; stf = 0;
            if (stl) begin
                pcf = 1; ifdf = 1; stf = 1;
                m_run++;
                m_stall++;
            end else begin
                m_run = 0;
                if (s.branch_taken) begin
                    ifdfl = 1; idxfl = 1; m_fl++;
                end else if (haz) begin
                    pcf = 1; ifdf = 1; idxfl = 1; m_bub++;
                end
            end
            if (to) m_err = 1'b1;
            e.outs = {req, pcf, ifdf, ifdfl, idxfl, stf, stf, stf, m_err};
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: one comparison per cycle at the falling edge.
    initial begin
        exp_t  e;
        string t;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                act = {mem_req, pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
                       id_exe_freeze, exe_mem_freeze, mem_wb_freeze, mem_timeout_err};
                n_vec++;
                if (act !== e.outs) begin
                    n_fail++;
                    $display("FAIL %s: outputs got %b expected %b (req,pcF,ifidF,ifidFl,idexFl,idexF,exmemF,memwbF,err)",
                             t, act, e.outs);
                end
`ifdef PIPE_PERF_CNT_EN
                n_vec++;
                if ({perf_stall_cycles, perf_bubbles, perf_flushes} !==
                    {e.stall_cnt, e.bub_cnt, e.fl_cnt}) begin
                    n_fail++;
                    $display("FAIL %s_perf: got stall=%0d bub=%0d fl=%0d expected stall=%0d bub=%0d fl=%0d",
                             t, perf_stall_cycles, perf_bubbles, perf_flushes,
                             e.stall_cnt, e.bub_cnt, e.fl_cnt);
                end
`endif
                $display("vec %0d %s outs=%b", n_vec, t, act);
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;

        // Reset
        s = idle(); s.rst = 1'b1;
        repeat (3) apply(s, "reset");
        s = idle();
        apply(s, "idle");

        // Load-use with forwarding
        s = idle();
        s.forward_en = 1; s.exe_mem_r_en = 1; s.exe_wb_en = 1; s.exe_dest = 3;
        s.id_src1 = 3; s.id_uses_src1 = 1;
        apply(s, "load_use");
        s.exe_mem_r_en = 0;
        apply(s, "fwd_no_load");
        // Same match but operand unused (MOV-type)
        s.exe_mem_r_en = 1; s.id_uses_src1 = 0;
        apply(s, "src1_unused");

        // No forwarding, MEM producer on src2
        s = idle();
        s.mem_wb_en = 1; s.mem_dest = 7; s.id_src2 = 7; s.id_two_src = 1; s.id_src1 = 1;
        apply(s, "nofwd_mem");
        s.id_two_src = 0;
        apply(s, "nofwd_one_src");

        // Register 15 matches like any other
        s = idle();
        s.exe_wb_en = 1; s.exe_dest = 15; s.id_src1 = 15; s.id_uses_src1 = 1;
        apply(s, "pc_reg15");

        // Memory wait: 4 stalled cycles then release
        s = idle(); s.mem_access = 1;
        repeat (4) apply(s, "mem_wait");
        s.mem_ready = 1;
        apply(s, "mem_release");
        s = idle();
        apply(s, "idle");

        // Branch held during a 3-cycle stall, flush once after release
        s = idle(); s.branch_taken = 1; s.mem_access = 1;
        repeat (3) apply(s, "br_stall");
        s.mem_ready = 1;
        apply(s, "br_flush");
        s = idle();
        apply(s, "br_done");

        // Branch with a simultaneous hazard: flush only
        s = idle(); s.branch_taken = 1;
        s.forward_en = 1; s.exe_mem_r_en = 1; s.exe_wb_en = 1; s.exe_dest = 5;
        s.id_src1 = 5; s.id_uses_src1 = 1;
        apply(s, "br_over_haz");

        // Timeout: 16 frozen cycles, abort cycle, then a fresh stall
        s = idle(); s.mem_access = 1;
        repeat (TIMEOUT) apply(s, "to_wait");
        apply(s, "to_abort");
        apply(s, "to_restall");
        s = idle();
        repeat (2) apply(s, "to_sticky");

        // Reset asserted mid-wait, then a full-length wait proves the counter cleared
        s = idle(); s.mem_access = 1;
        repeat (6) apply(s, "pre_rst_wait");
        s.rst = 1;
        repeat (2) apply(s, "rst_mid_wait");
        s = idle(); s.mem_access = 1;
        repeat (TIMEOUT + 1) apply(s, "post_rst_wait");
        s = idle();
        apply(s, "idle");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst          = ($urandom_range(0, 199) == 0);
            s.id_src1      = ($urandom_range(0, 7) == 0) ? 4'd15 : REG_W'($urandom_range(0, 3));
            s.id_src2      = ($urandom_range(0, 7) == 0) ? 4'd15 : REG_W'($urandom_range(0, 3));
            s.exe_dest     = ($urandom_range(0, 7) == 0) ? 4'd15 : REG_W'($urandom_range(0, 3));
            s.mem_dest     = REG_W'($urandom_range(0, 3));
            s.id_two_src   = 1'($urandom_range(0, 1));
            s.id_uses_src1 = 1'($urandom_range(0, 1));
            s.exe_wb_en    = 1'($urandom_range(0, 1));
            s.exe_mem_r_en = 1'($urandom_range(0, 1));
            s.mem_wb_en    = 1'($urandom_range(0, 1));
            s.forward_en   = 1'($urandom_range(0, 1));
            s.branch_taken = ($urandom_range(0, 6) == 0);
            s.mem_access   = ($urandom_range(0, 2) == 0);
            s.mem_ready    = 1'($urandom_range(0, 1));
            apply(s, "random");
        end

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while ((exp_q.size() > 0) && (guard < 10)) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
